// File: rtl/audio_effect_crossfader_if.sv
// Frame-level bus between the effect sources and the crossfader: source samples, control
// inputs and the mixed stereo output headed for the DAC.
interface audio_effect_crossfader_if #(
  parameter int NUM_SRC  = 6,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4
);
  localparam int SEL_W = $clog2(NUM_SRC + 1);

  logic                            sample_strobe;
  logic [NUM_SRC*2*SAMPLE_W-1:0]   src_data;
  logic [SEL_W-1:0]                sel;
  logic [GAIN_W-1:0]               gain;
  logic                            clip_clr;
  logic [2*SAMPLE_W-1:0]           dac_data;
  logic                            dac_valid;
  logic [SEL_W-1:0]                active_sel;
  logic                            fading;
  logic                            clip;

  modport master (
    output sample_strobe, src_data, sel, gain, clip_clr,
    input  dac_data, dac_valid, active_sel, fading, clip
  );

  modport slave (
    input  sample_strobe, src_data, sel, gain, clip_clr,
    output dac_data, dac_valid, active_sel, fading, clip
  );
endinterface

// File: rtl/audio_effect_crossfader.sv
// Stereo effect selector: linear crossfade between sources on every selection change,
// followed by a saturating Q.2 output gain. Two-stage pipeline from strobe to dac_valid.
module audio_effect_crossfader #(
  parameter int NUM_SRC   = 6,
  parameter int SAMPLE_W  = 16,
  parameter int FADE_LOG2 = 6,
  parameter int TONE_HALF = 240,
  parameter int TONE_AMP  = 15000,
  parameter int GAIN_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  audio_effect_crossfader_if.slave bus
);
  localparam int SEL_W  = $clog2(NUM_SRC + 1);
  localparam int W2     = 2 * SAMPLE_W;
  localparam int ACC_W  = SAMPLE_W + FADE_LOG2 + 2;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int TC_W   = $clog2(2 * TONE_HALF);

  localparam logic [SEL_W-1:0]            TONE_SEL    = SEL_W'(NUM_SRC);
  localparam logic [FADE_LOG2:0]          K_ONE       = {{FADE_LOG2{1'b0}}, 1'b1};
  localparam logic [FADE_LOG2:0]          K_FULL      = {1'b1, {FADE_LOG2{1'b0}}};
  localparam logic [TC_W-1:0]             TONE_HALF_C = TC_W'(TONE_HALF);
  localparam logic [TC_W-1:0]             TONE_LAST   = TC_W'(2 * TONE_HALF - 1);
  localparam logic signed [SAMPLE_W-1:0]  TONE_POS    = SAMPLE_W'(TONE_AMP);
  localparam logic signed [SAMPLE_W-1:0]  TONE_NEG    = -TONE_POS;
  localparam logic signed [PROD_W-1:0]    SAT_MAX     = PROD_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0]    SAT_MIN     = -SAT_MAX - PROD_W'(1);

  typedef enum logic {STEADY, FADE} state_e;

  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]            nxt_sel_q, nxt_sel_d;
  logic [FADE_LOG2:0]          k_q, k_d;
  logic [TC_W-1:0]             tone_cnt_q;
  logic                        s1_valid_q;
  logic signed [SAMPLE_W-1:0]  mix_l_q, mix_r_q;
  logic [W2-1:0]               dac_data_q;
  logic                        dac_valid_q;
  logic                        clip_q;

  logic [SEL_W-1:0]            sel_in;
  logic [SEL_W-1:0]            b_sel;
  logic [FADE_LOG2:0]          k_frame;
  logic signed [SAMPLE_W-1:0]  tone_s;
  logic [W2-1:0]               srcs [NUM_SRC+1];

  assign tone_s = (tone_cnt_q < TONE_HALF_C) ? TONE_POS : TONE_NEG;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign srcs[i] = bus.src_data[i*W2 +: W2];
  end
  assign srcs[NUM_SRC] = {tone_s, tone_s};

  // k_frame is the weight used for the frame being evaluated on this strobe, which can
  // differ from k_q: a new fade already mixes with k=1 on its first strobe.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    nxt_sel_d = nxt_sel_q;
    k_d       = k_q;
    k_frame   = '0;
    b_sel     = cur_sel_q;
    sel_in    = (bus.sel > TONE_SEL) ? '0 : bus.sel;
    if (bus.sample_strobe) begin
      case (state_q)
        STEADY: begin
          if (sel_in != cur_sel_q) begin
            k_frame   = K_ONE;
            b_sel     = sel_in;
            nxt_sel_d = sel_in;
            k_d       = K_ONE;
            state_d   = FADE;
          end
        end
        FADE: begin
          k_frame = k_q + K_ONE;
          b_sel   = nxt_sel_q;
          if (k_frame == K_FULL) begin
            cur_sel_d = nxt_sel_q;
            k_d       = '0;
            state_d   = STEADY;
          end else begin
            k_d = k_frame;
          end
        end
        default: state_d = STEADY;
      endcase
    end
  end

  logic [W2-1:0]              src_a, src_b;
  logic [FADE_LOG2:0]         w_a;
  logic signed [ACC_W-1:0]    a_l, a_r, b_l, b_r, wa_s, wb_s, acc_l, acc_r;
  logic signed [SAMPLE_W-1:0] mix_l, mix_r;

  always_comb begin
    src_a = srcs[cur_sel_q];
    src_b = srcs[b_sel];
    w_a   = K_FULL - k_frame;
    a_l   = $signed(src_a[W2-1:SAMPLE_W]);
    a_r   = $signed(src_a[SAMPLE_W-1:0]);
    b_l   = $signed(src_b[W2-1:SAMPLE_W]);
    b_r   = $signed(src_b[SAMPLE_W-1:0]);
    wa_s  = {{(ACC_W-FADE_LOG2-1){1'b0}}, w_a};
    wb_s  = {{(ACC_W-FADE_LOG2-1){1'b0}}, k_frame};
    acc_l = a_l * wa_s + b_l * wb_s;
    acc_r = a_r * wa_s + b_r * wb_s;
    mix_l = SAMPLE_W'(acc_l >>> FADE_LOG2);
    mix_r = SAMPLE_W'(acc_r >>> FADE_LOG2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= STEADY;
      cur_sel_q  <= '0;
      nxt_sel_q  <= '0;
      k_q        <= '0;
      tone_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      mix_l_q    <= '0;
      mix_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      nxt_sel_q  <= nxt_sel_d;
      k_q        <= k_d;
      s1_valid_q <= bus.sample_strobe;
      if (bus.sample_strobe) begin
        tone_cnt_q <= (tone_cnt_q == TONE_LAST) ? '0 : tone_cnt_q + TC_W'(1);
        mix_l_q    <= mix_l;
        mix_r_q    <= mix_r;
      end
    end
  end

  // Returns {saturated, value}; the product is taken at full width before the Q.2 shift.
  function automatic logic [SAMPLE_W:0] apply_gain(input logic signed [SAMPLE_W-1:0] m,
                                                   input logic [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] m_x, g_x, p;
    m_x = m;
    g_x = {{(PROD_W-GAIN_W){1'b0}}, g};
    p   = (m_x * g_x) >>> 2;
    if (p > SAT_MAX)      return {1'b1, SAT_MAX[SAMPLE_W-1:0]};
    else if (p < SAT_MIN) return {1'b1, SAT_MIN[SAMPLE_W-1:0]};
    else                  return {1'b0, p[SAMPLE_W-1:0]};
  endfunction

  logic [SAMPLE_W:0] g_l, g_r;
  assign g_l = apply_gain(mix_l_q, bus.gain);
  assign g_r = apply_gain(mix_r_q, bus.gain);

  // A saturating frame outranks a simultaneous clip_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      dac_valid_q <= s1_valid_q;
      if (s1_valid_q) dac_data_q <= {g_l[SAMPLE_W-1:0], g_r[SAMPLE_W-1:0]};
      if (s1_valid_q && (g_l[SAMPLE_W] || g_r[SAMPLE_W])) clip_q <= 1'b1;
      else if (bus.clip_clr)                               clip_q <= 1'b0;
    end
  end

  assign bus.dac_data   = dac_data_q;
  assign bus.dac_valid  = dac_valid_q;
  assign bus.active_sel = cur_sel_q;
  assign bus.fading     = (state_q == FADE);
  assign bus.clip       = clip_q;
endmodule
